// File: rtl/mem_dump_tx_if.sv
// Memory port-b read bus and UART byte-stream handshake used by mem_dump_tx.
// The master side is the streamer. The slave side is the memory plus the UART transmitter.
interface mem_dump_tx_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  mem_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_dr;
    logic [7:0]            tx_data;
    logic                  tx_stb;
    logic                  tx_ack;

    modport master (
        output mem_en, mem_addr, tx_data, tx_stb,
        input  mem_dr, tx_ack
    );

    modport slave (
        input  mem_en, mem_addr, tx_data, tx_stb,
        output mem_dr, tx_ack
    );
endinterface

// File: rtl/mem_dump_tx.sv
// Streams a range of 32-bit words from image memory port b to the UART as bytes.
// Each word is read once, latched into a shift register, and sent as four bytes.
module mem_dump_tx #(
    parameter int ADDR_WIDTH = 16,
    parameter bit LSB_FIRST  = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   word_count,
    output logic                busy,
    output logic                done,
    mem_dump_tx_if.master       bus
);

    typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, DONE} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH:0]   remaining;
    logic [31:0]           shreg;
    logic [1:0]            idx;
    logic                  hs;

    assign hs = (state == SEND) && bus.tx_ack;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        done       = 1'b0;
        bus.mem_en = 1'b0;
        bus.tx_stb = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = (word_count != '0) ? READ : DONE;
            READ: begin
                busy       = 1'b1;
                bus.mem_en = 1'b1;
                state_nxt  = WAIT;
            end
            WAIT: begin
                busy      = 1'b1;
                state_nxt = SEND;
            end
            SEND: begin
                busy       = 1'b1;
                bus.tx_stb = 1'b1;
                if (hs && idx == 2'd3) state_nxt = (remaining != '0) ? READ : DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr      <= '0;
            remaining <= '0;
            shreg     <= '0;
            idx       <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    addr      <= base_addr;
                    remaining <= word_count;
                end
                WAIT: begin
                    shreg     <= bus.mem_dr;
                    idx       <= '0;
                    addr      <= addr + 1'b1;
                    remaining <= remaining - 1'b1;
                end
                SEND: if (hs) begin
                    shreg <= LSB_FIRST ? {8'h00, shreg[31:8]} : {shreg[23:0], 8'h00};
                    idx   <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Drained bytes shift in zeros, so tx_data idles at 0 between words.
    assign bus.mem_addr = addr;
    assign bus.tx_data  = LSB_FIRST ? shreg[7:0] : shreg[31:24];

endmodule

// File: tb/tb_mem_dump_tx.sv
// Directed bench for mem_dump_tx: an LSB-first and an MSB-first instance run in lockstep
// against one memory model and one acknowledge generator.
module tb_mem_dump_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] base_addr;
    logic [16:0] word_count;
    logic        busy_l, done_l, busy_m, done_m;

    mem_dump_tx_if #(.ADDR_WIDTH(16)) lif ();
    mem_dump_tx_if #(.ADDR_WIDTH(16)) mif ();

    mem_dump_tx #(.ADDR_WIDTH(16), .LSB_FIRST(1'b1)) u_dut_lsb (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .word_count(word_count), .busy(busy_l), .done(done_l), .bus(lif));

    mem_dump_tx #(.ADDR_WIDTH(16), .LSB_FIRST(1'b0)) u_dut_msb (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .word_count(word_count), .busy(busy_m), .done(done_m), .bus(mif));

    always #5 clk = ~clk;

    logic [31:0] mem [0:65535];
    int cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (lif.mem_en) lif.mem_dr <= mem[lif.mem_addr];
        if (mif.mem_en) mif.mem_dr <= mem[mif.mem_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Monitor state, all owned by the initial process through tick().
    logic [7:0]  lsb_q[$], msb_q[$], exp_l[$], exp_m[$];
    logic [15:0] addr_q[$];
    int ack_mode, wait_cnt, done_cnt, msb_done_cnt, done_cyc, first_stb, e0;
    bit seen_busy, seen_stb, seen_en;

    // Advance to the next falling edge, drive tx_ack for this cycle and log what the DUT shows.
    task automatic tick();
        logic ack;
        @(negedge clk);
        case (ack_mode)
            0: ack = 1'b1;
            1: begin
                if (lif.tx_stb) begin
                    ack      = (wait_cnt == 2);
                    wait_cnt = ack ? 0 : wait_cnt + 1;
                end else begin
                    ack      = 1'b0;
                    wait_cnt = 0;
                end
            end
            3: ack = (lsb_q.size() != 2);
            default: ack = 1'b0;
        endcase
        lif.tx_ack = ack;
        mif.tx_ack = ack;
        if (lif.tx_stb && ack) lsb_q.push_back(lif.tx_data);
        if (mif.tx_stb && ack) msb_q.push_back(mif.tx_data);
        if (lif.mem_en) begin
            addr_q.push_back(lif.mem_addr);
            seen_en = 1'b1;
        end
        if (lif.tx_stb) begin
            seen_stb = 1'b1;
            if (first_stb < 0) first_stb = cyc;
        end
        if (busy_l) seen_busy = 1'b1;
        if (done_l) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (done_m) msb_done_cnt++;
    endtask

    task automatic start_xfer(input logic [15:0] b, input logic [16:0] n);
        lsb_q.delete(); msb_q.delete(); addr_q.delete(); exp_l.delete(); exp_m.delete();
        done_cnt = 0; msb_done_cnt = 0; done_cyc = -1; first_stb = -1; wait_cnt = 0;
        seen_busy = 1'b0; seen_stb = 1'b0; seen_en = 1'b0;
        start = 1'b1; base_addr = b; word_count = n;
        e0 = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done_cnt > 0) break;
        end
        repeat (4) tick();
    endtask

    task automatic expect_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            exp_l.push_back(w[8*i +: 8]);
            exp_m.push_back(w[8*(3-i) +: 8]);
        end
    endtask

    task automatic check_bytes(input string tag);
        check({tag, "_nbytes"}, lsb_q.size(), exp_l.size());
        check({tag, "_nbytes_msb"}, msb_q.size(), exp_m.size());
        for (int i = 0; i < exp_l.size(); i++) begin
            check($sformatf("%s_lsb%0d", tag, i), (i < lsb_q.size()) ? lsb_q[i] : 8'hxx, exp_l[i]);
            check($sformatf("%s_msb%0d", tag, i), (i < msb_q.size()) ? msb_q[i] : 8'hxx, exp_m[i]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy_l, 0);
        check({tag, "_done"}, done_l, 0);
        check({tag, "_mem_en"}, lif.mem_en, 0);
        check({tag, "_mem_addr"}, lif.mem_addr, 0);
        check({tag, "_tx_stb"}, lif.tx_stb, 0);
        check({tag, "_tx_data"}, lif.tx_data, 0);
        check({tag, "_msb_tx_stb"}, mif.tx_stb, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
        lif.tx_ack = 1'b0; mif.tx_ack = 1'b0; ack_mode = 0;
        mem[16'h0010] = 32'hDDCCBBAA;
        mem[16'hFFFF] = 32'h04030201;
        mem[16'h0000] = 32'h08070605;
        for (int i = 0; i < 4; i++) mem[16'h0100 + i] = 32'h13121110 + 32'h04040404 * i;
        mem[16'h0200] = 32'hEEEEEEEE;
        mem[16'h0300] = 32'h44332211;

        #1 check_reset_outputs("rst");
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Single word, acknowledge two cycles after each byte is offered.
        ack_mode = 1;
        start_xfer(16'h0010, 17'd1);
        wait_done(100);
        expect_word(32'hDDCCBBAA);
        check_bytes("w1");
        check("w1_done_cnt", done_cnt, 1);
        check("w1_msb_done_cnt", msb_done_cnt, 1);
        check("w1_reads", addr_q.size(), 1);
        check("w1_addr", addr_q[0], 16'h0010);

        // Address wrap with ack tied high: minimum-latency timing.
        ack_mode = 0;
        start_xfer(16'hFFFF, 17'd2);
        wait_done(100);
        expect_word(32'h04030201);
        expect_word(32'h08070605);
        check_bytes("wrap");
        check("wrap_reads", addr_q.size(), 2);
        check("wrap_addr0", addr_q[0], 16'hFFFF);
        check("wrap_addr1", addr_q[1], 16'h0000);
        check("wrap_first_stb", first_stb - e0, 3);
        check("wrap_done_lat", done_cyc - e0, 13);
        check("wrap_done_cnt", done_cnt, 1);

        // Zero-length request.
        start_xfer(16'h1234, 17'd0);
        wait_done(10);
        check("zero_done_lat", done_cyc - e0, 1);
        check("zero_done_cnt", done_cnt, 1);
        check("zero_busy", seen_busy, 0);
        check("zero_stb", seen_stb, 0);
        check("zero_mem_en", seen_en, 0);

        // A start mid-transfer must be ignored.
        start_xfer(16'h0100, 17'd4);
        repeat (8) tick();
        start = 1'b1; base_addr = 16'h0200; word_count = 17'd1;
        tick();
        start = 1'b0;
        wait_done(100);
        for (int i = 0; i < 4; i++) expect_word(32'h13121110 + 32'h04040404 * i);
        check_bytes("ign");
        check("ign_done_cnt", done_cnt, 1);
        check("ign_reads", addr_q.size(), 4);
        for (int i = 0; i < 4; i++)
            check($sformatf("ign_addr%0d", i), (i < addr_q.size()) ? addr_q[i] : 16'hxxxx, 16'h0100 + i);

        // Stall on byte 2, then reset during the stall.
        ack_mode = 3;
        start_xfer(16'h0300, 17'd1);
        for (int i = 0; i < 50 && lsb_q.size() < 2; i++) tick();
        check("stall_reached", lsb_q.size(), 2);
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("stall_stb%0d", i), lif.tx_stb, 1);
            check($sformatf("stall_data%0d", i), lif.tx_data, 8'h33);
            check($sformatf("stall_mdata%0d", i), mif.tx_data, 8'h22);
        end
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        repeat (3) tick();
        check("midrst_no_done", done_cnt, 0);
        check("midrst_no_msb_done", msb_done_cnt, 0);
        check("midrst_bytes", lsb_q.size(), 2);
        rst_n = 1'b1;
        tick();

        ack_mode = 0;
        start_xfer(16'h0010, 17'd1);
        wait_done(100);
        expect_word(32'hDDCCBBAA);
        check_bytes("post");
        check("post_done_lat", done_cyc - e0, 7);
        check("post_done_cnt", done_cnt, 1);
        check("post_addr", addr_q.size() > 0 ? addr_q[0] : 16'hxxxx, 16'h0010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_dump_tx.md
# mem_dump_tx

Memory-to-UART readback streamer for the edge-detection design. On a start pulse it reads a range of 32-bit words from port b of the dual-port image memory. It serializes each word into four bytes on the byte-stream handshake that feeds the UART transmitter, so the processed image can be returned to the PC without host-driven per-word commands. It is the read/transmit counterpart to the receive path that writes incoming bytes into memory.

## Interface
- ADDR_WIDTH, 16, memory word-address width
- LSB_FIRST, 1, 1: byte 0 = word[7:0] sent first; 0: word[31:24] sent first
- clk  in  1  system clock (divided clock domain shared with UART and memory)
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- base_addr  in  ADDR_WIDTH  first word address; captured on accepted start
- word_count  in  ADDR_WIDTH+1  number of words; captured on accepted start
- busy  out  1  high from the cycle after accepted start until DONE exits
- done  out  1  one-cycle pulse at end of transfer
- mem_en  out  1  memory port-b enable (read only; no write-enable output)
- mem_addr  out  ADDR_WIDTH  memory port-b word address
- mem_dr  in  32  memory read data, valid the cycle after mem_en
- tx_data  out  8  byte to UART
- tx_stb  out  1  byte valid; held with stable tx_data until acknowledged
- tx_ack  in  1  UART accepts byte in any cycle where tx_stb=1 and tx_ack=1

## Operation
- States: IDLE, READ, WAIT, SEND, DONE.
- IDLE: start=1 captures base_addr into the address counter and word_count into the remaining counter.
  - Remaining ≠ 0 -> READ.
  - Remaining = 0 -> DONE.
- READ: mem_en=1 and mem_addr=current address for exactly one cycle -> WAIT.
- WAIT: mem_dr latched into a 32-bit shift register at the end of the cycle. Byte index is cleared, the address is incremented, and remaining is decremented -> SEND.
- SEND: tx_stb=1. tx_data = shreg[7:0] (LSB_FIRST=1) or shreg[31:24] (LSB_FIRST=0).
  - On a handshake: shift by 8 toward the output end and increment the index.
  - Handshake while index=3:
    - Remaining ≠ 0 -> READ.
    - Remaining = 0 -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- Address arithmetic is modulo 2^ADDR_WIDTH. Example: base 0xFFFF with count 2 reads 0xFFFF, then 0x0000.
- word_count is ADDR_WIDTH+1 wide, so 2^ADDR_WIDTH words (the full memory) is expressible.
- start while not in IDLE is ignored. No queuing.
- tx_ack while tx_stb=0 is ignored.
- mem_en is 0 in all states except READ.

## Timing
- Reset values:
  - busy=0, done=0, mem_en=0, mem_addr=0, tx_stb=0, tx_data=0.
  - State=IDLE, all counters 0.
- Reset asserted mid-transfer: immediate return to reset values. An in-flight byte is abandoned and no done pulse is produced.
- Start accepted at edge E0 gives the following cycle-by-cycle sequence:
  - Cycle after E0: READ, with mem_en=1 and busy=1.
  - Next cycle: WAIT.
  - Next cycle: SEND, where tx_stb first rises, 3 cycles after E0.
- tx_ack may be high in the first cycle tx_stb is high. A byte completes in 1 cycle minimum.
- After a handshake on bytes 0–2:
  - The next byte is presented on the following cycle.
  - tx_stb stays high continuously across bytes of the same word.
  - tx_data changes only on the cycle after a handshake.
- Between words, tx_stb is low for exactly 2 cycles (READ, WAIT).
- Minimum word period is 6 cycles. N words with zero-wait ack take 6N+1 cycles from E0 to done.
- Count 0: done=1 in the cycle after E0. busy stays 0, and neither tx_stb nor mem_en asserts.
- busy drops in the same cycle done pulses (DONE is not busy).
- A new start is accepted in the cycle after done.

## Test plan
- Word 0xDDCCBBAA at addr 0x0010, base=0x0010, count=1, tx_ack returned 2 cycles after each tx_stb rise -> bytes AA, BB, CC, DD, in that order, then a single done pulse. mem_en pulses once with mem_addr=0x0010.
- Same memory with LSB_FIRST=0 -> bytes DD, CC, BB, AA.
- base=0xFFFF, count=2, memory[0xFFFF]=0x04030201, memory[0]=0x08070605, ack tied high -> bytes 01..08, mem_addr sequence 0xFFFF then 0x0000, done 13 cycles after start.
- count=0 -> done the cycle after start. busy, tx_stb and mem_en never assert.
- Mid-transfer of count=4, pulse start with different base -> ignored: all 16 bytes come from the original range, with exactly one done.
- Hold tx_ack low 20 cycles on byte 2 -> tx_stb and tx_data stable throughout. Assert rst_n=0 during the stall -> outputs immediately at reset values, no done. After release, a new start runs normally.
